// File: rtl/video_arb_pkg.sv
// -----------------------------------------------------------------------------
// video_arb_pkg
// Shared definitions for the video frame arbiter:
//   arb_state_e  - arbiter FSM states
//   tdata_width  - pixel width rounded up to whole bytes
//   AXIS_ID_W / AXIS_DEST_W - sideband widths of the AXI4-Stream interface
// -----------------------------------------------------------------------------
package video_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } arb_state_e;

    localparam int AXIS_ID_W   = 3;
    localparam int AXIS_DEST_W = 1;

    function automatic int tdata_width(input int px_width);
        return ((px_width + 7) / 8) * 8;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// -----------------------------------------------------------------------------
// axi4_stream_if
// AXI4-Stream bundle used for video: tuser = first pixel of frame,
// tlast = last pixel of line.
//   master: drives tdata/tstrb/tkeep/tuser/tlast/tvalid/tid/tdest, reads tready
//   slave : the reverse
// -----------------------------------------------------------------------------
interface axi4_stream_if
    import video_arb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ID_W   = AXIS_ID_W,
    parameter int DEST_W = AXIS_DEST_W
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [DATA_W/8-1:0] tkeep;
    logic                tuser;
    logic                tlast;
    logic                tvalid;
    logic                tready;
    logic [ID_W-1:0]     tid;
    logic [DEST_W-1:0]   tdest;

    modport master (output tdata, tstrb, tkeep, tuser, tlast, tvalid, tid, tdest,
                    input  tready);
    modport slave  (input  tdata, tstrb, tkeep, tuser, tlast, tvalid, tid, tdest,
                    output tready);
endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set request at or after ptr_i
// (wrapping) wins.
//   req_i - request vector
//   ptr_i - index where the search starts
//   gnt_o - one-hot grant, zero when no request
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            // (ptr + i) mod N without a divider; ptr < N so one subtract suffices
            sum = {1'b0, ptr_i} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
            idx = sum[PW-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/video_frame_arbiter.sv
// -----------------------------------------------------------------------------
// video_frame_arbiter
// Grants whole video frames from N_INPUTS streams onto one output stream.
//   clk_i, rst_n_i - clock, async active-low reset
//   video_i[]      - requesting streams (slave side)
//   video_o        - shared output stream, combinational pass-through of the
//                    granted input while in FRAME
//   grant_o        - one-hot owner of video_o, zero when idle
//   frame_done_o   - one-cycle pulse after the last line of a granted frame
//   sync_drop_o    - per input, high while that input discards mid-frame words
// -----------------------------------------------------------------------------
module video_frame_arbiter
    import video_arb_pkg::*;
#(
    parameter int N_INPUTS     = 2,
    parameter int PX_WIDTH     = 10,
    parameter int FRAME_HEIGHT = 1080
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    axi4_stream_if.slave        video_i [N_INPUTS],
    axi4_stream_if.master       video_o,
    output logic [N_INPUTS-1:0] grant_o,
    output logic                frame_done_o,
    output logic [N_INPUTS-1:0] sync_drop_o
);
    localparam int DW = tdata_width(PX_WIDTH);
    localparam int SW = DW / 8;
    localparam int PW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int CW = $clog2(FRAME_HEIGHT + 1);

    // flattened view of the interface array (interfaces need constant indices)
    logic [N_INPUTS-1:0]                  in_valid, in_user, in_last, in_ready;
    logic [N_INPUTS-1:0][DW-1:0]          in_data;
    logic [N_INPUTS-1:0][SW-1:0]          in_strb, in_keep;
    logic [N_INPUTS-1:0][AXIS_ID_W-1:0]   in_id;
    logic [N_INPUTS-1:0][AXIS_DEST_W-1:0] in_dest;

    for (genvar k = 0; k < N_INPUTS; k++) begin : g_in
        assign in_valid[k]        = video_i[k].tvalid;
        assign in_user[k]         = video_i[k].tuser;
        assign in_last[k]         = video_i[k].tlast;
        assign in_data[k]         = video_i[k].tdata;
        assign in_strb[k]         = video_i[k].tstrb;
        assign in_keep[k]         = video_i[k].tkeep;
        assign in_id[k]           = video_i[k].tid;
        assign in_dest[k]         = video_i[k].tdest;
        assign video_i[k].tready  = in_ready[k];
    end

    arb_state_e          state_q, state_d;
    logic [N_INPUTS-1:0] grant_q, grant_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       line_cnt_q, line_cnt_d;
    logic                frame_done_q, frame_done_d;
    // Low for the first cycle after reset so nothing is flushed while in reset
    logic                run_q, run_d;

    logic [N_INPUTS-1:0] req, rr_gnt, flush;
    logic [PW-1:0]       gidx, next_ptr;
    logic [CW-1:0]       cnt_base, cnt_inc;
    logic                beat;

    logic                out_valid, out_user, out_last;
    logic [DW-1:0]       out_data;
    logic [SW-1:0]       out_strb, out_keep;
    logic [AXIS_ID_W-1:0]   out_id;
    logic [AXIS_DEST_W-1:0] out_dest;

    assign req = in_valid & in_user;

    rr_arbiter #(.N(N_INPUTS)) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt)
    );

    // grant_q is only non-zero in FRAME, so the mux is idle-quiet by itself
    always_comb begin
        out_valid = 1'b0;
        out_user  = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        out_strb  = '0;
        out_keep  = '0;
        out_id    = '0;
        out_dest  = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (grant_q[k]) begin
                out_valid = in_valid[k];
                out_user  = in_user[k];
                out_last  = in_last[k];
                out_data  = in_data[k];
                out_strb  = in_strb[k];
                out_keep  = in_keep[k];
                out_id    = in_id[k];
                out_dest  = in_dest[k];
            end
        end
    end

    assign video_o.tvalid = out_valid;
    assign video_o.tuser  = out_user;
    assign video_o.tlast  = out_last;
    assign video_o.tdata  = out_data;
    assign video_o.tstrb  = out_strb;
    assign video_o.tkeep  = out_keep;
    assign video_o.tid    = out_id;
    assign video_o.tdest  = out_dest;

    // Non-granted inputs sitting mid-frame drain until a frame start shows up;
    // the tuser word itself is left at the head (tready=0) for arbitration.
    assign flush       = run_q ? (in_valid & ~in_user & ~grant_q) : '0;
    assign in_ready    = (grant_q & {N_INPUTS{video_o.tready}}) | flush;
    assign sync_drop_o = flush;
    assign grant_o     = grant_q;
    assign frame_done_o = frame_done_q;

    assign beat = out_valid & video_o.tready;

    always_comb begin
        gidx = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (grant_q[k]) gidx = PW'(k);
        end
        if (int'(gidx) == N_INPUTS - 1) next_ptr = '0;
        else                             next_ptr = gidx + 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        line_cnt_d   = line_cnt_q;
        frame_done_d = 1'b0;
        run_d        = 1'b1;
        cnt_base     = line_cnt_q;
        cnt_inc      = line_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d = rr_gnt;
                    state_d = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (beat) begin
                    // tuser mid-frame: re-sync to a new frame, keep the grant
                    cnt_base = (out_user && line_cnt_q != '0) ? '0 : line_cnt_q;
                    cnt_inc  = cnt_base + CW'(out_last);
                    if (out_last && cnt_inc == CW'(FRAME_HEIGHT)) begin
                        state_d      = ST_IDLE;
                        grant_d      = '0;
                        line_cnt_d   = '0;
                        frame_done_d = 1'b1;
                        ptr_d        = next_ptr;
                    end else begin
                        line_cnt_d   = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            ptr_q        <= '0;
            line_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            line_cnt_q   <= line_cnt_d;
            frame_done_q <= frame_done_d;
            run_q        <= run_d;
        end
    end
endmodule

// File: tb/tb_video_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_video_frame_arbiter
// Random-data frame sources on two inputs, a word-level scoreboard per input
// (expected forwarded words, frame lengths, discard counts) and grant-order
// expectations per phase.
// -----------------------------------------------------------------------------
module tb_video_frame_arbiter;
    typedef struct packed {
        logic        user;
        logic        last;
        logic [15:0] data;
    } word_t;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       out_rdy;
    logic [1:0] grant_o, sync_drop_o;
    logic       frame_done_o;
    logic [1:0] s_valid, s_user, s_last, s_ready;
    logic [1:0][15:0] s_data;

    axi4_stream_if #(.DATA_W(16)) vin [2] ();
    axi4_stream_if #(.DATA_W(16)) vout ();

    for (genvar k = 0; k < 2; k++) begin : g_src
        assign vin[k].tvalid = s_valid[k];
        assign vin[k].tuser  = s_user[k];
        assign vin[k].tlast  = s_last[k];
        assign vin[k].tdata  = s_data[k];
        assign vin[k].tstrb  = 2'b11;
        assign vin[k].tkeep  = 2'b11;
        assign vin[k].tid    = 3'(k);
        assign vin[k].tdest  = 1'b0;
        assign s_ready[k]    = vin[k].tready;
    end
    assign vout.tready = out_rdy;

    video_frame_arbiter #(
        .N_INPUTS     (2),
        .PX_WIDTH     (10),
        .FRAME_HEIGHT (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .video_i      (vin),
        .video_o      (vout),
        .grant_o      (grant_o),
        .frame_done_o (frame_done_o),
        .sync_drop_o  (sync_drop_o)
    );

    always #5 clk_i = ~clk_i;

    // scoreboard
    word_t src_q [2][$];
    word_t exp_q [2][$];
    int    len_q [2][$];
    int    gseq[$];
    int    exp_gseq[$];
    int    exp_drop [2];
    int    drop_cnt [2];
    int    out_cnt  [2];
    int    n_done, beats, cur_g;
    logic  fr_act;
    logic [1:0] prev_g;
    logic  rnd_rdy, gap_en;
    int    n_chk, n_fail;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // lines of 8 pixels, first pixel carries tuser
    task automatic gen_lines(input int k, input int lines);
        word_t w;
        for (int l = 0; l < lines; l++) begin
            for (int b = 0; b < 8; b++) begin
                w.user = (l == 0 && b == 0);
                w.last = (b == 7);
                w.data = 16'($urandom);
                src_q[k].push_back(w);
                exp_q[k].push_back(w);
            end
        end
    endtask

    task automatic gen_frame(input int k);
        gen_lines(k, 4);
        len_q[k].push_back(32);
    endtask

    task automatic gen_garbage(input int k, input int n);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.user = 1'b0;
            w.last = 1'($urandom_range(0, 1));
            w.data = 16'($urandom);
            src_q[k].push_back(w);
        end
        exp_drop[k] += n;
    endtask

    // sample at negedge, drive just after posedge
    initial begin : drv_mon
        logic [1:0] acc;
        word_t ow, w;
        s_valid = '0; s_user = '0; s_last = '0; s_data = '0;
        out_rdy = 1'b1;
        forever begin
            @(negedge clk_i);
            for (int k = 0; k < 2; k++) acc[k] = s_valid[k] && s_ready[k];
            if (grant_o != 2'b00) begin
                chk("grant_onehot", 32'($onehot(grant_o)), 1);
                if (prev_g == 2'b00) begin
                    chk("prev_done", 32'(fr_act), 0);
                    cur_g  = grant_o[1] ? 1 : 0;
                    gseq.push_back(cur_g);
                    beats  = 0;
                    fr_act = 1'b1;
                end else begin
                    chk("grant_stable", 32'(grant_o), 32'(prev_g));
                end
            end else begin
                chk("idle_tvalid", 32'(vout.tvalid), 0);
            end
            if (vout.tvalid && vout.tready) begin
                ow = {vout.tuser, vout.tlast, vout.tdata};
                chk("beat_in_frame", 32'(fr_act), 1);
                if (fr_act) begin
                    chk("beat_tid", 32'(vout.tid), 32'(cur_g));
                    chk("beat_pending", 32'(exp_q[cur_g].size() > 0), 1);
                    if (exp_q[cur_g].size() > 0) chk("beat_word", 32'(ow), 32'(exp_q[cur_g].pop_front()));
                    beats++;
                    out_cnt[cur_g]++;
                end
            end
            if (frame_done_o) begin
                chk("done_idle", 32'(grant_o), 0);
                chk("done_in_frame", 32'(fr_act), 1);
                n_done++;
                if (fr_act) begin
                    chk("len_known", 32'(len_q[cur_g].size() > 0), 1);
                    if (len_q[cur_g].size() > 0) chk("frame_len", beats, len_q[cur_g].pop_front());
                end
                fr_act = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                if (sync_drop_o[k]) begin
                    drop_cnt[k]++;
                    chk("drop_word", 32'(s_valid[k] && s_ready[k] && !s_user[k] && !grant_o[k]), 1);
                end
                if (s_valid[k] && s_user[k] && !grant_o[k])
                    chk("hold_user", 32'(s_ready[k]), 0);
            end
            prev_g = grant_o;

            @(posedge clk_i);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (acc[k]) void'(src_q[k].pop_front());
                if (!(s_valid[k] && !acc[k])) begin
                    if (src_q[k].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
                        w = src_q[k][0];
                        s_valid[k] = 1'b1;
                        s_user[k]  = w.user;
                        s_last[k]  = w.last;
                        s_data[k]  = w.data;
                    end else begin
                        s_valid[k] = 1'b0;
                    end
                end
            end
            out_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // called at posedge+3; an in-flight frame's remaining words become discards
    task automatic do_reset();
        int n;
        rst_n_i = 1'b0;
        #1;
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_tvalid", 32'(vout.tvalid), 0);
        chk("rst_done", 32'(frame_done_o), 0);
        chk("rst_drop", 32'(sync_drop_o), 0);
        chk("rst_ready", 32'(s_ready), 0);
        if (fr_act) begin
            n = len_q[cur_g].pop_front() - beats;
            for (int i = 0; i < n; i++) void'(exp_q[cur_g].pop_front());
            exp_drop[cur_g] += n;
            fr_act = 1'b0;
        end
        repeat (2) @(posedge clk_i);
        #3;
        rst_n_i = 1'b1;
    endtask

    task automatic run_phase(input int done_exp, input int oc0, input int oc1);
        int cyc = 0;
        while ((src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size() != 0
                || grant_o != 2'b00 || s_valid != 2'b00) && cyc < 4000) begin
            @(posedge clk_i); #3;
            cyc++;
        end
        chk("phase_timeout", 32'(cyc < 4000), 1);
        repeat (3) @(posedge clk_i);
        #3;
        chk("n_done", n_done, done_exp);
        chk("gseq_len", gseq.size(), exp_gseq.size());
        for (int i = 0; i < exp_gseq.size(); i++)
            if (i < gseq.size()) chk("gseq", gseq[i], exp_gseq[i]);
        chk("out_cnt0", out_cnt[0], oc0);
        chk("out_cnt1", out_cnt[1], oc1);
        chk("drops0", drop_cnt[0], exp_drop[0]);
        chk("drops1", drop_cnt[1], exp_drop[1]);
        n_done = 0;
        gseq.delete();
        exp_gseq.delete();
        out_cnt[0] = 0;
        out_cnt[1] = 0;
    endtask

    initial begin : main
        int cyc;
        rst_n_i = 1'b0;
        n_chk = 0; n_fail = 0; n_done = 0; beats = 0; cur_g = 0;
        fr_act = 1'b0; prev_g = 2'b00; rnd_rdy = 1'b0; gap_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_drop[k] = 0; drop_cnt[k] = 0; out_cnt[k] = 0;
        end
        @(posedge clk_i); #3;
        do_reset();

        // input 0 alone, two frames
        gen_frame(0); gen_frame(0);
        exp_gseq.push_back(0); exp_gseq.push_back(0);
        run_phase(2, 64, 0);

        // fresh reset, both inputs request together
        @(posedge clk_i); #3;
        do_reset();
        gen_frame(0); gen_frame(0); gen_frame(1); gen_frame(1);
        exp_gseq.push_back(0); exp_gseq.push_back(1); exp_gseq.push_back(0); exp_gseq.push_back(1);
        run_phase(4, 64, 64);

        // input 1 joins mid-frame while input 0 owns the output
        gen_frame(0);
        cyc = 0;
        while (grant_o != 2'b01 && cyc < 100) begin @(posedge clk_i); #3; cyc++; end
        chk("grant0_wait", 32'(grant_o), 32'h1);
        gen_garbage(1, 3);
        gen_frame(1);
        exp_gseq.push_back(0); exp_gseq.push_back(1);
        run_phase(2, 32, 32);

        // random backpressure and source gaps
        rnd_rdy = 1'b1; gap_en = 1'b1;
        gen_frame(0); gen_frame(0); gen_frame(1); gen_frame(1);
        exp_gseq.push_back(0); exp_gseq.push_back(1); exp_gseq.push_back(0); exp_gseq.push_back(1);
        run_phase(4, 64, 64);
        rnd_rdy = 1'b0; gap_en = 1'b0;

        // tuser after two lines restarts the line count, grant kept
        gen_lines(0, 2);
        gen_lines(0, 4);
        len_q[0].push_back(48);
        exp_gseq.push_back(0);
        run_phase(1, 48, 0);

        // reset after line 2, then a clean frame
        gen_frame(0);
        cyc = 0;
        while (out_cnt[0] < 16 && cyc < 200) begin @(posedge clk_i); #3; cyc++; end
        chk("mid_frame_wait", 32'(out_cnt[0] >= 16), 1);
        do_reset();
        gen_frame(0);
        exp_gseq.push_back(0); exp_gseq.push_back(0);
        run_phase(1, 48, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
